// File: rtl/mean_pkg.sv
// Shared types and width helpers for the windowed lane-mean datapath.
// Latency: n/a (compile-time package only).
// Backpressure: n/a.
// Contents: round_mode_e, lane_sum_w/acc_w width helpers, clamp_log2.
package mean_pkg;

  typedef enum logic {
    TRUNC = 1'b0,
    RHU   = 1'b1
  } round_mode_e;

  // Width of the zero-extended sum of all lanes in one beat.
  function automatic int lane_sum_w(input int bus, input int data);
    return data + $clog2(bus);
  endfunction

  // Accumulator width that holds a full window of the largest size.
  function automatic int acc_w(input int bus, input int data, input int max_log2);
    return lane_sum_w(bus, data) + max_log2;
  endfunction

  // Window sizes beyond the supported maximum fall back to the maximum.
  function automatic int clamp_log2(input int v, input int max_log2);
    return (v > max_log2) ? max_log2 : v;
  endfunction

endpackage

// File: rtl/mean_lane_adder.sv
// Combinational sum of all lanes of one beat, zero-extended to LANE_SUM_W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows its inputs.
// Ports: i_data (lanes, unpacked), o_sum (lane sum).
module mean_lane_adder
  import mean_pkg::*;
#(
  parameter  int BUS_WIDTH  = 4,
  parameter  int DATA_WIDTH = 6,
  localparam int LANE_SUM_W = lane_sum_w(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] i_data [0:BUS_WIDTH-1],
  output logic [LANE_SUM_W-1:0] o_sum
);

  logic [LANE_SUM_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      w_sum = w_sum + LANE_SUM_W'(i_data[i]);
    end
  end

  assign o_sum = w_sum;

endmodule

// File: rtl/mean_window.sv
// Streaming mean over a 2^k-beat window of BUS_WIDTH-lane beats, truncated or round-half-up.
// Latency: 1 cycle from acceptance of the final beat of a window to o_valid.
// Backpressure: single output register; i_ready = !o_valid || o_ready.
// Ports: clk/rst_n, cfg_log2_beats/cfg_round (latched per window), i_clear,
//        i_valid/i_ready/i_data (input beats), o_valid/o_ready/o_data (window mean).
module mean_window
  import mean_pkg::*;
#(
  parameter int BUS_WIDTH      = 4,
  parameter int DATA_WIDTH     = 6,
  parameter int MAX_LOG2_BEATS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [$clog2(MAX_LOG2_BEATS+1)-1:0]     cfg_log2_beats,
  input  logic                                    cfg_round,
  input  logic                                    i_clear,
  input  logic                                    i_valid,
  output logic                                    i_ready,
  input  logic [DATA_WIDTH-1:0]                   i_data [0:BUS_WIDTH-1],
  output logic                                    o_valid,
  input  logic                                    o_ready,
  output logic [DATA_WIDTH-1:0]                   o_data
);

  localparam int LANE_SUM_W = lane_sum_w(BUS_WIDTH, DATA_WIDTH);
  localparam int ACC_W      = acc_w(BUS_WIDTH, DATA_WIDTH, MAX_LOG2_BEATS);
  localparam int CNT_W      = MAX_LOG2_BEATS + 1;
  localparam int LOG2_W     = $clog2(MAX_LOG2_BEATS + 1);
  localparam int BUS_LOG2   = $clog2(BUS_WIDTH);
  localparam int SHIFT_W    = $clog2(ACC_W + 1);

  generate
    if ((BUS_WIDTH < 1) || ((BUS_WIDTH & (BUS_WIDTH - 1)) != 0)) begin : g_bad_bus
      $fatal(1, "mean_window: BUS_WIDTH must be a power of 2");
    end
  endgenerate

  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [LOG2_W-1:0]     r_win_log2;
  round_mode_e           r_win_round;
  logic                  r_o_valid;
  logic [DATA_WIDTH-1:0] r_o_data;

  logic [LANE_SUM_W-1:0] w_lane_sum;
  logic                  w_accept;
  logic                  w_first;
  logic [LOG2_W-1:0]     w_cfg_clamped;
  logic [LOG2_W-1:0]     w_eff_log2;
  round_mode_e           w_eff_round;
  logic [CNT_W-1:0]      w_last_cnt;
  logic                  w_final;
  logic [SHIFT_W-1:0]    w_shift;
  logic [ACC_W-1:0]      w_bias;
  logic [ACC_W-1:0]      w_total;
  logic [DATA_WIDTH-1:0] w_mean;

  mean_lane_adder #(
    .BUS_WIDTH  (BUS_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_adder (
    .i_data (i_data),
    .o_sum  (w_lane_sum)
  );

  assign i_ready  = !r_o_valid || o_ready;
  assign w_accept = i_valid && i_ready;
  assign w_first  = (r_beat_cnt == '0);

  // On the first beat of a window the live config applies directly, so a
  // one-beat window closes on the same beat that latches its settings.
  assign w_cfg_clamped = LOG2_W'(clamp_log2(int'(cfg_log2_beats), MAX_LOG2_BEATS));
  assign w_eff_log2    = w_first ? w_cfg_clamped : r_win_log2;
  assign w_eff_round   = w_first ? round_mode_e'(cfg_round) : r_win_round;

  assign w_last_cnt = (CNT_W'(1) << w_eff_log2) - CNT_W'(1);
  assign w_final    = (r_beat_cnt == w_last_cnt);

  // Divide by lanes * beats; half an LSB of bias gives round-half-up.
  assign w_shift = SHIFT_W'(BUS_LOG2) + SHIFT_W'(w_eff_log2);
  assign w_bias  = ((w_eff_round == RHU) && (w_shift != '0))
                 ? (ACC_W'(1) << (w_shift - SHIFT_W'(1))) : '0;
  // Sum stays below 2^(shift+DATA_WIDTH), so it fits ACC_W and the mean fits DATA_WIDTH.
  assign w_total = r_acc + ACC_W'(w_lane_sum) + w_bias;
  assign w_mean  = DATA_WIDTH'(w_total >> w_shift);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_beat_cnt  <= '0;
      r_win_log2  <= '0;
      r_win_round <= TRUNC;
      r_o_valid   <= 1'b0;
      r_o_data    <= '0;
    end else begin
      if (w_accept && w_first) begin
        r_win_log2  <= w_cfg_clamped;
        r_win_round <= round_mode_e'(cfg_round);
      end

      // Clear drops the partial window and any beat accepted alongside it.
      if (i_clear) begin
        r_acc      <= '0;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        if (w_final) begin
          r_acc      <= '0;
          r_beat_cnt <= '0;
        end else begin
          r_acc      <= r_acc + ACC_W'(w_lane_sum);
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
      end

      // A new mean on the same edge as the consumer's accept keeps o_valid high.
      if (w_accept && w_final && !i_clear) begin
        r_o_valid <= 1'b1;
        r_o_data  <= w_mean;
      end else if (o_ready) begin
        r_o_valid <= 1'b0;
      end
    end
  end

  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;

endmodule

// File: tb/tb_mean_window.sv
// Directed self-checking bench for mean_window (BUS_WIDTH=4, DATA_WIDTH=6, MAX_LOG2_BEATS=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Expected means are hand-computed: (sum + bias) >> (2 + log2 beats).
module tb_mean_window;

  localparam int BW = 4;
  localparam int DW = 6;
  localparam int ML = 4;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b1;
  logic [$clog2(ML+1)-1:0]      cfg_log2_beats = '0;
  logic                         cfg_round = 1'b0;
  logic                         i_clear = 1'b0;
  logic                         i_valid = 1'b0;
  logic                         i_ready;
  logic [DW-1:0]                i_data [0:BW-1];
  logic                         o_valid;
  logic                         o_ready = 1'b1;
  logic [DW-1:0]                o_data;

  int n_cmp = 0;
  int n_err = 0;

  mean_window #(
    .BUS_WIDTH      (BW),
    .DATA_WIDTH     (DW),
    .MAX_LOG2_BEATS (ML)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_log2_beats (cfg_log2_beats),
    .cfg_round      (cfg_round),
    .i_clear        (i_clear),
    .i_valid        (i_valid),
    .i_ready        (i_ready),
    .i_data         (i_data),
    .o_valid        (o_valid),
    .o_ready        (o_ready),
    .o_data         (o_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input int a, input int b, input int c, input int d);
    i_data[0] = DW'(a);
    i_data[1] = DW'(b);
    i_data[2] = DW'(c);
    i_data[3] = DW'(d);
  endtask

  task automatic fill(input int v);
    set_lanes(v, v, v, v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    fill(0);

    // Reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_o_data", 32'(o_data), 0);
    chk("rst_i_ready", 32'(i_ready), 1);
    rst_n = 1'b1;
    tick();

    // 1: single-beat window, truncate then round
    cfg_log2_beats = 0; cfg_round = 0;
    set_lanes(1, 2, 3, 4); i_valid = 1;
    tick();
    chk("t1_trunc_valid", 32'(o_valid), 1);
    chk("t1_trunc_data", 32'(o_data), 2);
    cfg_round = 1;
    tick();
    chk("t1_round_valid", 32'(o_valid), 1);
    chk("t1_round_data", 32'(o_data), 3);
    i_valid = 0;
    tick();
    chk("t1_drain", 32'(o_valid), 0);

    // 2: four-beat window, round-half-up
    cfg_log2_beats = 2; cfg_round = 1;
    fill(63); i_valid = 1;
    tick(); tick(); tick();
    chk("t2_partial", 32'(o_valid), 0);
    tick();
    chk("t2_max_valid", 32'(o_valid), 1);
    chk("t2_max_data", 32'(o_data), 63);
    set_lanes(0, 0, 1, 0);
    tick();
    fill(0);
    tick(); tick(); tick();
    chk("t2_small_valid", 32'(o_valid), 1);
    chk("t2_small_data", 32'(o_data), 0);
    i_valid = 0;
    tick();

    // 3: output backpressure
    cfg_log2_beats = 0; cfg_round = 0;
    fill(4); i_valid = 1;
    tick();
    chk("t3_first_data", 32'(o_data), 4);
    o_ready = 0; fill(8);
    #1;
    chk("t3_stall_ready", 32'(i_ready), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", 32'(o_valid), 1);
      chk("t3_hold_data", 32'(o_data), 4);
    end
    o_ready = 1;
    #1;
    chk("t3_release_ready", 32'(i_ready), 1);
    tick();
    chk("t3_b2b_valid", 32'(o_valid), 1);
    chk("t3_b2b_data", 32'(o_data), 8);
    i_valid = 0;
    tick();
    chk("t3_drain", 32'(o_valid), 0);

    // 4: config change mid-window is deferred
    cfg_log2_beats = 1; cfg_round = 0;
    fill(2); i_valid = 1;
    tick();
    cfg_log2_beats = 3; fill(6);
    tick();
    chk("t4_short_valid", 32'(o_valid), 1);
    chk("t4_short_data", 32'(o_data), 4);
    for (int k = 0; k < 7; k++) begin
      fill(k);
      tick();
    end
    chk("t4_long_partial", 32'(o_valid), 0);
    fill(7);
    tick();
    chk("t4_long_valid", 32'(o_valid), 1);
    chk("t4_long_data", 32'(o_data), 3);
    i_valid = 0;
    tick();

    // 5: clear discards the partial window, and a coincident beat
    cfg_log2_beats = 2; cfg_round = 0;
    fill(10); i_valid = 1;
    tick(); tick();
    chk("t5_pre_clear", 32'(o_valid), 0);
    i_valid = 0; i_clear = 1;
    tick();
    i_clear = 0; fill(5); i_valid = 1;
    tick(); tick(); tick();
    chk("t5_after_clear_partial", 32'(o_valid), 0);
    tick();
    chk("t5_clear_valid", 32'(o_valid), 1);
    chk("t5_clear_data", 32'(o_data), 5);
    fill(60); i_clear = 1;
    tick();
    i_clear = 0; fill(5);
    tick(); tick(); tick();
    chk("t5_dropped_partial", 32'(o_valid), 0);
    tick();
    chk("t5_dropped_valid", 32'(o_valid), 1);
    chk("t5_dropped_data", 32'(o_data), 5);
    i_valid = 0;
    tick();

    // 6a: async reset mid-window
    cfg_log2_beats = 1; cfg_round = 0;
    fill(63); i_valid = 1;
    tick();
    i_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_midwin_valid", 32'(o_valid), 0);
    rst_n = 1'b1;
    tick();
    fill(8); i_valid = 1;
    tick();
    fill(4);
    tick();
    chk("t6_fresh_valid", 32'(o_valid), 1);
    chk("t6_fresh_data", 32'(o_data), 6);

    // 6b: async reset with a result pending
    cfg_log2_beats = 0;
    fill(9);
    tick();
    o_ready = 0; i_valid = 0;
    tick();
    chk("t6_pending_valid", 32'(o_valid), 1);
    chk("t6_pending_data", 32'(o_data), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(o_valid), 0);
    chk("t6_rst_data", 32'(o_data), 0);
    rst_n = 1'b1;
    tick();
    chk("t6_post_ready", 32'(i_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
